// File: rtl/jk_excitation_sequencer_if.sv
// Request channel into the JK excitation sequencer: one next-state bit per transfer.
interface jk_excitation_sequencer_if;
  logic in_valid;
  logic in_ready;
  logic in_bit;

  modport master (output in_valid, output in_bit, input in_ready);
  modport slave  (input in_valid, input in_bit, output in_ready);
endinterface

// File: rtl/jk_excitation_sequencer.sv
// Upstream driver for a master-slave JK stage: queues requested next-state bits,
// converts each into a one-cycle J/K excitation from the fed-back q, then checks
// that the stage settled to the requested value.
module jk_excitation_sequencer #(
  parameter int unsigned DEPTH       = 4,
  parameter bit          TOGGLE_PREF = 1'b1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  jk_excitation_sequencer_if.slave    req,
  input  logic                        q_fb,
  output logic                        j,
  output logic                        k,
  output logic                        busy,
  output logic                        err,
  output logic [CNT_W-1:0]            err_count,
  output logic [CNT_W-1:0]            done_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = AW + 1;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t          state;
  logic [DEPTH-1:0] mem;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [OW-1:0]   occ;
  logic            tgt;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            head;

  // FIFO status and handshake; pops happen only on the edge that enters DRIVE
  assign full         = (occ == OW'(DEPTH));
  assign empty        = (occ == '0);
  assign head         = mem[rd_ptr];
  assign push         = req.in_valid && !full;
  assign pop          = !empty && ((state == IDLE) || (state == CHECK));
  assign req.in_ready = !full;
  assign busy         = (state != IDLE) || !empty;

  // J/K pair that moves the flop from cur to t
  function automatic logic [1:0] excite(input logic cur, input logic t);
    if (cur == t) return 2'b00;
    if (TOGGLE_PREF) return 2'b11;
    return t ? 2'b10 : 2'b01;
  endfunction

  // Saturating increment for the status counters
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Request FIFO storage, pointers (wrap at power-of-two DEPTH) and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= req.in_bit;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Sequencer FSM: j/k are non-zero only while in DRIVE, err pulses for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tgt        <= 1'b0;
      j          <= 1'b0;
      k          <= 1'b0;
      err        <= 1'b0;
      err_count  <= '0;
      done_count <= '0;
    end else begin
      j   <= 1'b0;
      k   <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            tgt    <= head;
            {j, k} <= excite(q_fb, head);
            state  <= DRIVE;
          end
        end
        DRIVE: begin
          state <= CHECK;
        end
        CHECK: begin
          if (q_fb != tgt) begin
            err       <= 1'b1;
            err_count <= sat_inc(err_count);
          end
          done_count <= sat_inc(done_count);
          if (!empty) begin
            tgt    <= head;
            {j, k} <= excite(q_fb, head);
            state  <= DRIVE;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_excitation_sequencer.sv
// Directed bench: three sequencer instances (toggle preference, set/reset preference,
// narrow counters with a stuck feedback) with behavioural master-slave JK stages.
module tb_jk_excitation_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  jk_excitation_sequencer_if ia ();
  jk_excitation_sequencer_if ib ();
  jk_excitation_sequencer_if ic ();

  logic       a_j, a_k, a_busy, a_err, a_q = 1'b0, a_m = 1'b0, a_stuck = 1'b0, a_qfb;
  logic [7:0] a_ec, a_dc;
  logic       b_j, b_k, b_busy, b_err, b_q = 1'b0, b_m = 1'b0;
  logic [7:0] b_ec, b_dc;
  logic       c_j, c_k, c_busy, c_err;
  logic [1:0] c_ec, c_dc;
  logic       c_qfb;

  assign a_qfb = a_stuck ? 1'b0 : a_q;
  assign c_qfb = 1'b0;

  jk_excitation_sequencer u_a (
    .clk(clk), .rst(rst), .req(ia.slave), .q_fb(a_qfb), .j(a_j), .k(a_k),
    .busy(a_busy), .err(a_err), .err_count(a_ec), .done_count(a_dc));

  jk_excitation_sequencer #(.TOGGLE_PREF(1'b0)) u_b (
    .clk(clk), .rst(rst), .req(ib.slave), .q_fb(b_q), .j(b_j), .k(b_k),
    .busy(b_busy), .err(b_err), .err_count(b_ec), .done_count(b_dc));

  jk_excitation_sequencer #(.CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .req(ic.slave), .q_fb(c_qfb), .j(c_j), .k(c_k),
    .busy(c_busy), .err(c_err), .err_count(c_ec), .done_count(c_dc));

  function automatic logic jk_next(input logic j, input logic k, input logic q);
    case ({j, k})
      2'b10:   return 1'b1;
      2'b01:   return 1'b0;
      2'b11:   return ~q;
      default: return q;
    endcase
  endfunction

  // JK stage A: master samples on posedge, slave follows on negedge
  always @(posedge clk) a_m <= rst ? 1'b0 : jk_next(a_j, a_k, a_q);
  always @(negedge clk) a_q <= a_m;
  // JK stage B
  always @(posedge clk) b_m <= rst ? 1'b0 : jk_next(b_j, b_k, b_q);
  always @(negedge clk) b_q <= b_m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [9:0] bits;
  int         occ;
  int         idx;
  logic       acc;
  logic       popm;
  int         m;

  // Directed sequence of all scenarios
  initial begin
    ia.in_valid = 1'b0; ia.in_bit = 1'b0;
    ib.in_valid = 1'b0; ib.in_bit = 1'b0;
    ic.in_valid = 1'b0; ic.in_bit = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    chk("rst_j", a_j, 0);
    chk("rst_k", a_k, 0);
    chk("rst_err", a_err, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_ready", ia.in_ready, 1);
    chk("rst_ec", a_ec, 0);
    chk("rst_dc", a_dc, 0);
    chk("rst_q", a_q, 0);

    // single request 1 from q=0 with toggle preference
    ia.in_valid = 1'b1; ia.in_bit = 1'b1;
    tick();
    ia.in_valid = 1'b0;
    chk("t1_busy", a_busy, 1);
    tick();
    chk("t1_jk", {a_j, a_k}, 2'b11);
    tick();
    chk("t1_jk_off", {a_j, a_k}, 2'b00);
    tick();
    chk("t1_q", a_q, 1);
    chk("t1_err", a_err, 0);
    chk("t1_dc", a_dc, 1);
    tick();
    chk("t1_idle", a_busy, 0);

    // back-to-back stream that fills the FIFO; model occupancy and check order via q
    bits = 10'b0010111001;
    occ = 0;
    idx = 0;
    for (int n = 0; n < 22; n++) begin
      ia.in_valid = (idx < 10);
      ia.in_bit   = (idx < 10) ? bits[idx] : 1'b0;
      chk("t3_ready", ia.in_ready, (occ < 4));
      acc  = ia.in_valid && (occ < 4);
      popm = ((n % 2) == 1) && (occ > 0);
      tick();
      occ = occ + int'(acc) - int'(popm);
      if (acc) idx++;
      if (n >= 3 && (n % 2) == 1) chk("t3_q", a_q, bits[(n - 3) / 2]);
    end
    ia.in_valid = 1'b0;
    chk("t3_pushed", idx, 10);
    chk("t3_dc", a_dc, 11);
    chk("t3_ec", a_ec, 0);
    chk("t3_busy", a_busy, 0);

    // stuck feedback: one mismatch gives one err pulse
    a_stuck = 1'b1;
    ia.in_valid = 1'b1; ia.in_bit = 1'b1;
    tick();
    ia.in_valid = 1'b0;
    tick();
    chk("t4_jk", {a_j, a_k}, 2'b11);
    tick();
    chk("t4_err_early", a_err, 0);
    tick();
    chk("t4_err", a_err, 1);
    chk("t4_ec", a_ec, 1);
    chk("t4_dc", a_dc, 12);
    tick();
    chk("t4_err_clear", a_err, 0);
    a_stuck = 1'b0;

    // set/reset preference: 1,1,0 from q=0
    ib.in_valid = 1'b1; ib.in_bit = 1'b1;
    tick();
    tick();
    chk("t2_jk0", {b_j, b_k}, 2'b10);
    ib.in_bit = 1'b0;
    tick();
    ib.in_valid = 1'b0;
    chk("t2_gap", {b_j, b_k}, 2'b00);
    tick();
    chk("t2_jk1", {b_j, b_k}, 2'b00);
    chk("t2_q0", b_q, 1);
    tick();
    tick();
    chk("t2_jk2", {b_j, b_k}, 2'b01);
    chk("t2_q1", b_q, 1);
    tick();
    tick();
    chk("t2_q2", b_q, 0);
    chk("t2_ec", b_ec, 0);
    chk("t2_dc", b_dc, 3);

    // narrow counters saturate while err keeps pulsing
    ic.in_bit = 1'b1;
    for (int n = 0; n < 12; n++) begin
      ic.in_valid = (n < 5);
      tick();
      if (n >= 3 && (n % 2) == 1) begin
        m = (n - 3) / 2 + 1;
        if (m > 3) m = 3;
        chk("t6_err", c_err, 1);
        chk("t6_ec", c_ec, m);
        chk("t6_dc", c_dc, m);
      end else if (n >= 2) begin
        chk("t6_err_low", c_err, 0);
      end
    end
    ic.in_valid = 1'b0;

    // reset while DRIVE with three requests queued
    ia.in_valid = 1'b1;
    for (int n = 0; n < 6; n++) begin
      ia.in_bit = n[0];
      tick();
    end
    ia.in_valid = 1'b0;
    chk("t5_busy_pre", a_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_jk", {a_j, a_k}, 2'b00);
    chk("t5_busy", a_busy, 0);
    chk("t5_ec", a_ec, 0);
    chk("t5_dc", a_dc, 0);
    chk("t5_ready", ia.in_ready, 1);
    chk("t5_b_dc", b_dc, 0);
    tick();
    chk("t5_q", a_q, 0);
    chk("t5_still_idle", a_busy, 0);
    chk("t5_err", a_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
